// File: rtl/nf_sume_10g_tx_rdy_sequencer_pkg.sv
// Shared definitions for the 10G TXUSERRDY sequencer: state encodings,
// default timing constants and a constant-evaluable clog2.
package nf_sume_10g_tx_rdy_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_DELAY     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_READY     = 3'd3,
        ST_RETRY     = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    localparam int DEF_NUM_LANES           = 4;
    localparam int DEF_SYNC_STAGES         = 4;
    localparam int DEF_RDY_DELAY_CYCLES    = 64;
    localparam int DEF_DONE_TIMEOUT_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES         = 2;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nf_sume_sync_bit.sv
// Single-bit multi-flop synchroniser into clk; clr empties the chain
// asynchronously (used both for reset and for fast lock-loss detection).
module nf_sume_sync_bit #(
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sreg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) sreg <= '0;
        else     sreg <= {sreg[STAGES-2:0], d};
    end

    assign q = sreg[STAGES-1];

endmodule

// File: rtl/nf_sume_10g_tx_rdy_sequencer.sv
// Sequences TXUSERRDY for lanes sharing one QPLL: lock, settle, assert, then
// supervise tx_resetdone with timeout, bounded retry and a sticky fault.
module nf_sume_10g_tx_rdy_sequencer
    import nf_sume_10g_tx_rdy_sequencer_pkg::*;
#(
    parameter int NUM_LANES           = DEF_NUM_LANES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int RDY_DELAY_CYCLES    = DEF_RDY_DELAY_CYCLES,
    parameter int DONE_TIMEOUT_CYCLES = DEF_DONE_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                 txusrclk2,
    input  logic                 gttxreset,
    input  logic                 qplllock,
    input  logic [NUM_LANES-1:0] lane_enable,
    input  logic [NUM_LANES-1:0] tx_resetdone,
    output logic [NUM_LANES-1:0] txuserrdy,
    output logic                 tx_ready_all,
    output logic                 tx_retry_req,
    output logic                 fault,
    output logic [2:0]           retry_count,
    output logic [2:0]           seq_state
);

    localparam int DLY_W = clog2_f(RDY_DELAY_CYCLES) + 1;
    localparam int TO_W  = clog2_f(DONE_TIMEOUT_CYCLES) + 1;
    localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(RDY_DELAY_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(DONE_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

    logic                 rst_n_sync;
    logic                 rst;
    logic                 lock_clr;
    logic                 lock_s;
    logic [NUM_LANES-1:0] en;
    logic [NUM_LANES-1:0] done;
    logic [NUM_LANES-1:0] en_ref;
    logic                 all_done;
    logic                 rdy_now;
    logic                 rdy_next;
    logic [DLY_W-1:0]     dly_cnt;
    logic [TO_W-1:0]      to_cnt;
    seq_state_t           state;
    seq_state_t           state_nxt;

    nf_sume_sync_bit #(.STAGES(SYNC_STAGES)) u_rst_bridge (
        .clk(txusrclk2), .clr(gttxreset), .d(1'b1), .q(rst_n_sync)
    );
    assign rst = ~rst_n_sync;

    // Clearing the chain while qplllock is low makes lock loss visible at once,
    // while lock rise still has to ripple through every stage.
    assign lock_clr = gttxreset | ~qplllock;

    nf_sume_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk(txusrclk2), .clr(lock_clr), .d(qplllock), .q(lock_s)
    );

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        nf_sume_sync_bit #(.STAGES(SYNC_STAGES)) u_en_sync (
            .clk(txusrclk2), .clr(gttxreset), .d(lane_enable[g]), .q(en[g])
        );
        nf_sume_sync_bit #(.STAGES(SYNC_STAGES)) u_done_sync (
            .clk(txusrclk2), .clr(gttxreset), .d(tx_resetdone[g]), .q(done[g])
        );
    end

    assign all_done = ((done & en) == en);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_WAIT_LOCK: if (lock_s && (en != '0)) state_nxt = ST_DELAY;
            ST_DELAY: begin
                if (!lock_s)                  state_nxt = ST_WAIT_LOCK;
                else if (dly_cnt == DLY_LAST) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!lock_s)                 state_nxt = ST_WAIT_LOCK;
                else if (all_done)           state_nxt = ST_READY;
                else if (to_cnt == TO_LAST)  state_nxt = ST_RETRY;
            end
            ST_READY: begin
                if (!lock_s)            state_nxt = ST_WAIT_LOCK;
                else if (en != en_ref)  state_nxt = ST_WAIT_LOCK;
                else if (!all_done)     state_nxt = ST_RETRY;
            end
            ST_RETRY: state_nxt = (retry_count < RETRY_MAX) ? ST_WAIT_LOCK : ST_FAULT;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_WAIT_LOCK;
        endcase
    end

    // txuserrdy comes up one cycle after WAIT_DONE entry but drops on the
    // same edge the FSM leaves the ready phase.
    assign rdy_now  = (state == ST_WAIT_DONE) || (state == ST_READY);
    assign rdy_next = (state_nxt == ST_WAIT_DONE) || (state_nxt == ST_READY);

    always_ff @(posedge txusrclk2 or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT_LOCK;
            dly_cnt     <= '0;
            to_cnt      <= '0;
            retry_count <= '0;
            txuserrdy   <= '0;
            en_ref      <= '0;
        end else begin
            state     <= state_nxt;
            en_ref    <= (state == ST_READY) ? en_ref : en;
            txuserrdy <= (rdy_now && rdy_next) ? en : '0;

            if (state == ST_DELAY && state_nxt == ST_DELAY)
                dly_cnt <= (dly_cnt == '1) ? dly_cnt : dly_cnt + 1'b1;
            else
                dly_cnt <= '0;

            if (state == ST_WAIT_DONE && state_nxt == ST_WAIT_DONE)
                to_cnt <= (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
            else
                to_cnt <= '0;

            if (state == ST_RETRY && retry_count < RETRY_MAX)
                retry_count <= retry_count + 3'd1;
        end
    end

    assign tx_ready_all = (state == ST_READY);
    assign tx_retry_req = (state == ST_RETRY);
    assign fault        = (state == ST_FAULT);
    assign seq_state    = state;

endmodule

// File: tb/tb_nf_sume_10g_tx_rdy_sequencer.sv
// Bench for the TXUSERRDY sequencer: a table of enable/done patterns run
// through a scoreboard, plus hand sequences for lock loss, retry, race, reset.
module tb_nf_sume_10g_tx_rdy_sequencer;

    logic       txusrclk2 = 1'b0;
    logic       gttxreset = 1'b1;
    logic       qplllock = 1'b0;
    logic [3:0] lane_enable = 4'h0;
    logic [3:0] tx_resetdone = 4'h0;
    logic [3:0] txuserrdy;
    logic       tx_ready_all;
    logic       tx_retry_req;
    logic       fault;
    logic [2:0] retry_count;
    logic [2:0] seq_state;

    nf_sume_10g_tx_rdy_sequencer #(
        .NUM_LANES(4), .SYNC_STAGES(4), .RDY_DELAY_CYCLES(64),
        .DONE_TIMEOUT_CYCLES(1024), .MAX_RETRIES(2)
    ) dut (
        .txusrclk2(txusrclk2), .gttxreset(gttxreset), .qplllock(qplllock),
        .lane_enable(lane_enable), .tx_resetdone(tx_resetdone),
        .txuserrdy(txuserrdy), .tx_ready_all(tx_ready_all),
        .tx_retry_req(tx_retry_req), .fault(fault),
        .retry_count(retry_count), .seq_state(seq_state)
    );

    always #5 txusrclk2 = ~txusrclk2;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] done;
        logic [3:0] exp_rdy;
    } vec_t;

    vec_t vecs[6];
    vec_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   viol_cnt = 0;

    // Any txuserrdy bit on a disabled lane is an error.
    always @(negedge txusrclk2) begin
        if ((txuserrdy & ~lane_enable) != 4'h0) viol_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge txusrclk2);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] en);
        gttxreset = 1'b1;
        qplllock = 1'b0;
        tx_resetdone = 4'h0;
        lane_enable = en;
        tick(3);
        gttxreset = 1'b0;
        tick(6);
    endtask

    task automatic wait_rdy(input int limit, output int n);
        n = 0;
        while (txuserrdy == 4'h0 && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_ready_all(input int limit, output int n);
        n = 0;
        while (!tx_ready_all && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   v0;
        int   pulses;
        int   last_pulse;
        int   min_gap;
        int   cyc;
        int   exp_cnt_q[$];
        vec_t cur;

        vecs[0] = '{en: 4'hF, done: 4'hF, exp_rdy: 4'hF};
        vecs[1] = '{en: 4'h5, done: 4'h5, exp_rdy: 4'h5};
        vecs[2] = '{en: 4'hA, done: 4'hA, exp_rdy: 4'hA};
        vecs[3] = '{en: 4'h8, done: 4'hF, exp_rdy: 4'h8};
        vecs[4] = '{en: 4'h3, done: 4'h7, exp_rdy: 4'h3};
        vecs[5] = '{en: 4'hF, done: 4'hF, exp_rdy: 4'hF};

        // Reset state
        tick(3);
        check("rst_txuserrdy", int'(txuserrdy), 0);
        check("rst_ready_all", int'(tx_ready_all), 0);
        check("rst_retry_req", int'(tx_retry_req), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_retry_count", int'(retry_count), 0);
        check("rst_seq_state", int'(seq_state), 0);

        // Normal bring-up with lock at cycle 10 and done later
        do_reset(4'hF);
        tick(4);
        qplllock = 1'b1;
        wait_rdy(200, n);
        check("bringup_rdy_latency_ok", int'(n >= 69 && n <= 71), 1);
        check("bringup_txuserrdy", int'(txuserrdy), 15);
        check("bringup_state_wait_done", int'(seq_state), 2);
        tick(30);
        tx_resetdone = 4'hF;
        wait_ready_all(50, n);
        check("bringup_ready_latency_ok", int'(n >= 4 && n <= 6), 1);
        check("bringup_fault", int'(fault), 0);
        check("bringup_state_ready", int'(seq_state), 3);

        // Table of enable / done patterns through the scoreboard
        for (int i = 0; i < 6; i++) begin
            do_reset(vecs[i].en);
            v0 = viol_cnt;
            qplllock = 1'b1;
            wait_rdy(200, n);
            check($sformatf("vec%0d_rdy_before_done", i), int'(txuserrdy), int'(vecs[i].exp_rdy));
            exp_q.push_back(vecs[i]);
            tx_resetdone = vecs[i].done;
            wait_ready_all(50, n);
            check($sformatf("vec%0d_ready_reached", i), int'(tx_ready_all), 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check($sformatf("vec%0d_txuserrdy", i), int'(txuserrdy), int'(cur.exp_rdy));
                check($sformatf("vec%0d_fault", i), int'(fault), 0);
            end
            tick(10);
            check($sformatf("vec%0d_disabled_lanes", i), viol_cnt - v0, 0);
        end

        // Lock loss in READY, then relock repeats the full delay
        qplllock = 1'b0;
        n = 0;
        while (txuserrdy != 4'h0 && n < 10) begin
            tick(1);
            n++;
        end
        check("lockloss_drop_within_3", int'(n <= 3), 1);
        tick(1);
        check("lockloss_state", int'(seq_state), 0);
        check("lockloss_retry_count", int'(retry_count), 0);
        tick(5);
        qplllock = 1'b1;
        wait_rdy(200, n);
        check("relock_delay_ok", int'(n >= 69 && n <= 71), 1);
        wait_ready_all(20, n);
        check("relock_ready", int'(tx_ready_all), 1);

        // Enable change in READY forces a full resequence
        lane_enable = 4'h3;
        n = 0;
        while (seq_state != 3'd0 && n < 10) begin
            tick(1);
            n++;
        end
        check("enchg_wait_lock", int'(seq_state), 0);
        wait_ready_all(200, n);
        check("enchg_ready", int'(tx_ready_all), 1);
        check("enchg_txuserrdy", int'(txuserrdy), 3);

        // Timeout, retries and fault with one lane never done
        do_reset(4'hF);
        tx_resetdone = 4'h7;
        qplllock = 1'b1;
        exp_cnt_q.push_back(1);
        exp_cnt_q.push_back(2);
        exp_cnt_q.push_back(2);
        pulses = 0;
        last_pulse = -100000;
        min_gap = 100000;
        cyc = 0;
        while (!fault && cyc < 4000) begin
            tick(1);
            cyc++;
            if (tx_retry_req) begin
                pulses++;
                if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
                last_pulse = cyc;
                tick(1);
                cyc++;
                check("retry_pulse_width", int'(tx_retry_req), 0);
                if (exp_cnt_q.size() != 0)
                    check("retry_count_after_pulse", int'(retry_count), exp_cnt_q.pop_front());
            end
        end
        check("retry_pulses", pulses, 3);
        check("retry_spacing_ok", int'(min_gap >= 1088), 1);
        check("fault_set", int'(fault), 1);
        check("fault_state", int'(seq_state), 5);
        check("fault_txuserrdy", int'(txuserrdy), 0);
        tick(20);
        check("fault_sticky", int'(fault), 1);
        check("fault_retry_count", int'(retry_count), 2);
        gttxreset = 1'b1;
        #1;
        check("fault_cleared_by_reset", int'(fault), 0);
        check("retry_count_cleared", int'(retry_count), 0);

        // Done completes on the same cycle as the timeout: done wins
        do_reset(4'hF);
        qplllock = 1'b1;
        wait_rdy(200, n);
        tick(1018);
        tx_resetdone = 4'hF;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (tx_retry_req) pulses++;
        end
        check("race_no_retry", pulses, 0);
        check("race_ready", int'(tx_ready_all), 1);

        // One cycle later the timeout must win
        do_reset(4'hF);
        qplllock = 1'b1;
        wait_rdy(200, n);
        tick(1019);
        tx_resetdone = 4'hF;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (tx_retry_req) pulses++;
        end
        check("late_done_retry", pulses, 1);
        check("late_done_retry_count", int'(retry_count), 1);

        // Reset mid-DELAY: async drop, then a full delay after release
        do_reset(4'hF);
        qplllock = 1'b1;
        n = 0;
        while (seq_state != 3'd1 && n < 50) begin
            tick(1);
            n++;
        end
        tick(30);
        check("mid_delay_state", int'(seq_state), 1);
        @(negedge txusrclk2);
        gttxreset = 1'b1;
        #1;
        check("mid_delay_async_state", int'(seq_state), 0);
        check("mid_delay_async_rdy", int'(txuserrdy), 0);
        tick(3);
        gttxreset = 1'b0;
        wait_rdy(200, n);
        check("mid_delay_restart_ok", int'(n >= 68 && n <= 74), 1);
        check("mid_delay_fault", int'(fault), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
